// File: rtl/mux_quad4_1.sv
// Four-lane, WIDTH-bit 4:1 multiplexer with a combinational output and an
// enable-gated registered copy. Each output bit is a tree of three 2:1
// selections so an unknown select bit merges candidates bit by bit.
module mux_quad4_1 #(
  parameter int unsigned           WIDTH     = 4,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  input  logic [WIDTH-1:0] InC,
  input  logic [WIDTH-1:0] InD,
  input  logic [1:0]       S,
  input  logic             en,
  output logic [WIDTH-1:0] Out,
  output logic [WIDTH-1:0] Out_r
);

  logic [WIDTH-1:0] ab_sel;
  logic [WIDTH-1:0] cd_sel;
  logic [WIDTH-1:0] out_q;

  // Per-bit selection tree: bit k sees only bit k of each lane.
  // The ?: operator merges both arms when the select is X/Z, leaving
  // agreeing bits intact and differing bits X.
  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    assign ab_sel[k] = S[0] ? InB[k] : InA[k];
    assign cd_sel[k] = S[0] ? InD[k] : InC[k];
    assign Out[k]    = S[1] ? cd_sel[k] : ab_sel[k];
  end

  // Output register: async reset to RESET_VAL, loads the selected lane when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= RESET_VAL;
    end else if (en) begin
      out_q <= Out;
    end
  end

  assign Out_r = out_q;

endmodule

// File: tb/tb_mux_quad4_1.sv
// Self-checking bench for mux_quad4_1: vector table, hand-written register and
// reset sequences, X-select checks and a randomized run against a lane-array model.
module tb_mux_quad4_1;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   s;
  logic [W-1:0] ina, inb, inc, ind;
  logic [W-1:0] out, out_r;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]   s;
    logic [W-1:0] a, b, c, d;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[$];

  mux_quad4_1 #(
    .WIDTH    (W),
    .RESET_VAL(4'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .InA  (ina),
    .InB  (inb),
    .InC  (inc),
    .InD  (ind),
    .S    (s),
    .en   (en),
    .Out  (out),
    .Out_r(out_r)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Reference: the lanes as an array, indexed by the select value modulo 4.
  function automatic logic [W-1:0] ref_sel(input int sel, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic [W-1:0] c,
                                           input logic [W-1:0] d);
    logic [W-1:0] lanes[4];
    lanes = '{a, b, c, d};
    return lanes[sel % 4];
  endfunction

  task automatic drive(input logic [1:0] sel, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    s = sel; ina = a; inb = b; inc = c; ind = d;
  endtask

  logic [W-1:0] exp_r;
  logic [W-1:0] nxt_r;
  logic         xprobe;
  logic [W-1:0] xexp;

  initial begin
    // Reset state, Out follows selection during reset
    rst_n = 1'b0; en = 1'b0;
    drive(2'd0, '0, '0, '0, '0);
    #1;
    check("reset_out_r", out_r, 4'h0);
    drive(2'd1, 4'h1, 4'h5, 4'h2, 4'h3);
    #1;
    check("out_in_reset", out, 4'h5);
    en = 1'b1;
    @(posedge clk); #1;
    check("reset_holds_on_clk", out_r, 4'h0);

    // Release coincident with an edge: that edge must not load
    @(negedge clk);
    drive(2'd2, 4'h0, 4'h0, 4'h9, 4'h0);
    @(posedge clk);
    rst_n <= 1'b1;
    #1;
    check("release_edge_no_load", out_r, 4'h0);
    @(posedge clk); #1;
    check("load_c9", out_r, 4'h9);

    // Hold with en=0 while Out tracks new data
    @(negedge clk);
    en = 1'b0; inc = 4'h3;
    @(posedge clk); #1;
    check("hold_out_r", out_r, 4'h9);
    check("out_tracks_c3", out, 4'h3);

    // Async reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_r", out_r, 4'h0);
    check("async_reset_out", out, 4'h3);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table: sweep, worked example, lane independence
    for (int j = 0; j < 20; j++) begin
      for (int sel = 0; sel < 4; sel++) begin
        vec_t v;
        v.s = 2'(sel);
        v.a = W'(j % 3); v.b = W'(j % 5); v.c = W'(j % 7); v.d = W'(j % 11);
        v.exp = ref_sel(sel, v.a, v.b, v.c, v.d);
        tbl.push_back(v);
      end
    end
    tbl.push_back('{s: 2'd3, a: 4'd1, b: 4'd2, c: 4'd0, d: 4'd7, exp: 4'd7});
    tbl.push_back('{s: 2'd1, a: 4'd1, b: 4'd2, c: 4'd0, d: 4'd7, exp: 4'd2});
    tbl.push_back('{s: 2'd0, a: 4'b1010, b: 4'b0101, c: 4'b1111, d: 4'b0000, exp: 4'hA});
    tbl.push_back('{s: 2'd1, a: 4'b1010, b: 4'b0101, c: 4'b1111, d: 4'b0000, exp: 4'h5});
    tbl.push_back('{s: 2'd2, a: 4'b1010, b: 4'b0101, c: 4'b1111, d: 4'b0000, exp: 4'hF});
    tbl.push_back('{s: 2'd3, a: 4'b1010, b: 4'b0101, c: 4'b1111, d: 4'b0000, exp: 4'h0});
    foreach (tbl[i]) begin
      drive(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
      #10;
      check($sformatf("table_%0d", i), out, tbl[i].exp);
    end

    // Wide select from a 4-bit counter, truncated to 2 bits
    for (int cnt = 0; cnt < 16; cnt++) begin
      logic [3:0] wide;
      logic [W-1:0] pattern[4];
      pattern = '{4'd1, 4'd2, 4'd0, 4'd7};
      wide = 4'(cnt);
      drive(2'(wide), 4'd1, 4'd2, 4'd0, 4'd7);
      #10;
      check($sformatf("wide_sel_%0d", cnt), out, pattern[cnt % 4]);
    end

    // Unknown select: agreeing lanes pass through, differing bits go X
    xprobe = 1'bx;
    drive(2'bxx, 4'd6, 4'd6, 4'd6, 4'd6);
    #1;
    check("x_sel_equal_lanes", out, 4'd6);
    if ($isunknown(xprobe)) begin
      drive(2'bxx, 4'b0110, 4'b0111, 4'b1110, 4'b0100);
      xexp = 4'bx1xx;
      #1;
      check("x_sel_diff_lanes", out, xexp);
    end

    // Randomized run with register scoreboard
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    drive(2'd0, 4'h0, 4'h0, 4'h0, 4'h0);
    @(posedge clk);
    exp_r = 4'h0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      drive(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      en = 1'($urandom);
      #1;
      check("rand_out", out, ref_sel(int'(s), ina, inb, inc, ind));
      nxt_r = en ? ref_sel(int'(s), ina, inb, inc, ind) : exp_r;
      @(posedge clk);
      exp_r = nxt_r;
      #1;
      check("rand_out_r", out_r, exp_r);
      // Mid-cycle input changes must not disturb the register
      drive(2'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      #1;
      check("rand_out_r_stable", out_r, exp_r);
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        exp_r = 4'h0;
        #1;
        check("rand_async_reset", out_r, exp_r);
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux_quad4_1.md
MUX_QUAD4_1 -- requirements
Module: mux_quad4_1

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the bit width of each data lane.
REQ-002 The block SHALL have parameter RESET_VAL, default 0, setting the value that Out_r takes on reset.

Ports:
REQ-003 The block SHALL have port clk, input, width 1, the single clock; all sequential logic uses its rising edge.
REQ-004 The block SHALL have port rst_n, input, width 1, reset; asynchronous, active-low.
REQ-005 The block SHALL have port InA, input, width WIDTH, data lane selected by S=0.
REQ-006 The block SHALL have port InB, input, width WIDTH, data lane selected by S=1.
REQ-007 The block SHALL have port InC, input, width WIDTH, data lane selected by S=2.
REQ-008 The block SHALL have port InD, input, width WIDTH, data lane selected by S=3.
REQ-009 The block SHALL have port S, input, width 2, lane select.
REQ-010 The block SHALL have port en, input, width 1, load enable for Out_r.
REQ-011 The block SHALL have port Out, output, width WIDTH, combinational selected lane.
REQ-012 The block SHALL have port Out_r, output, width WIDTH, registered copy of Out.

Function
REQ-013 Out SHALL equal InA when S=0, InB when S=1, InC when S=2 and InD when S=3, bit for bit across all WIDTH bits.
REQ-014 Out SHALL be purely combinational, with no clock or reset dependence.
REQ-015 Out SHALL settle within one simulation delta of any change to S or the data lanes, so it is stable well within 10 time units.
REQ-016 Each output bit SHALL be built from three 2:1 selections:
- level 1: S[0] chooses A/B and C/D;
- level 2: S[1] chooses between the two level-1 results.
REQ-017 The selection SHALL be lane-independent: bit k of Out depends only on bit k of the four lanes and on S.
REQ-018 If S contains X or Z, Out SHALL be X on every bit where the candidate lanes differ.
REQ-019 If S contains X or Z, Out SHALL equal the common value on every bit where all candidate lanes agree.
REQ-020 On each rising clk edge with rst_n=1 and en=1, Out_r SHALL load the Out value present before the edge.
REQ-021 On each rising clk edge with rst_n=1 and en=0, Out_r SHALL hold its value.
REQ-022 Out_r latency SHALL be exactly one clock after the inputs are applied.
REQ-023 Changes to S or the data lanes between clock edges SHALL NOT affect Out_r.
REQ-024 Values wider than 2 bits driven onto S SHALL be truncated by the connection, so S=4..15 behave as S mod 4, e.g. 5 selects InB.
REQ-025 The block SHALL contain no state other than the WIDTH-bit Out_r register.

Reset
REQ-026 When rst_n falls, Out_r SHALL become RESET_VAL immediately, independent of clk.
REQ-027 While rst_n=0, Out_r SHALL hold RESET_VAL regardless of clk and en.
REQ-028 While rst_n=0, Out SHALL continue to follow REQ-013.
REQ-029 If rst_n rises on the same edge as clk, that edge SHALL NOT load Out_r; the first load occurs on the next rising edge with en=1.
REQ-030 Reset asserted mid-operation SHALL discard the registered value with no residual state.

Verification
REQ-031 Exhaustive combinational sweep: for S=0..3, drive InA=j%3, InB=j%5, InC=j%7, InD=j%11 for j=0..19 and wait 10 time units -> Out equals the lane selected by S.
- Example j=7: A=1, B=2, C=0, D=7; S=3 gives Out=7 and S=1 gives Out=2.
REQ-032 Wide select: drive S from a 4-bit counter 0..15 with A=1, B=2, C=0, D=7 -> Out repeats 1, 2, 0, 7 every four steps.
REQ-033 Lane independence: InA=4'b1010, InB=4'b0101, InC=4'b1111, InD=4'b0000 -> Out=A, B, F, 0 (hex) for S=0, 1, 2, 3.
REQ-034 Register path: rst_n=0 -> Out_r=0. Then release rst_n, set en=1, S=2, InC=9 and apply one clk edge -> Out_r=9. Then set en=0, change InC to 3 and apply an edge -> Out_r stays 9 while Out=3.
REQ-035 Async reset: with Out_r=9, pull rst_n low between clock edges -> Out_r becomes 0 immediately while Out is unchanged.
REQ-036 X select: S=2'bx with InA=InB=InC=InD=6 -> Out=6. With the lanes differing -> the differing bits of Out are X.
